// File: rtl/branch_pred.sv
// Branch resolution unit with a bimodal 2-bit predictor table.
// Prediction is a combinational table read; resolution is registered.
module branch_pred #(
   parameter int XLEN      = 32,
   parameter int BHT_DEPTH = 64,
   parameter int CNT_W     = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [XLEN-1:0]  i_pc_f,
   output logic             o_pred_taken,
   input  logic             i_valid,
   input  logic [XLEN-1:0]  i_pc_e,
   input  logic [XLEN-1:0]  i_dat_a,
   input  logic [XLEN-1:0]  i_dat_b,
   input  logic [2:0]       i_funct3,
   input  logic             i_branch,
   input  logic             i_jump,
   input  logic             i_pred,
   input  logic             i_flush,
   output logic             o_valid,
   output logic             o_br_en,
   output logic             o_mispredict,
   output logic [CNT_W-1:0] o_mispred_cnt
);

   localparam int IDX = $clog2(BHT_DEPTH);

   logic [1:0]     bht [BHT_DEPTH];
   logic [IDX-1:0] idx_f;
   logic [IDX-1:0] idx_e;
   logic           eq;
   logic           lt_s;
   logic           lt_u;
   logic           cmp;
   logic           cond;
   logic           taken;
   logic           accept;
   logic           upd;
   logic           miss;
   logic [1:0]     cur;
   logic [1:0]     nxt;
   logic           unused_pc;

   assign idx_f = i_pc_f[IDX+1:2];
   assign idx_e = i_pc_e[IDX+1:2];
   assign unused_pc = ^{i_pc_f[XLEN-1:IDX+2], i_pc_f[1:0],
                        i_pc_e[XLEN-1:IDX+2], i_pc_e[1:0]};

   // Old table value is returned even when the same entry updates this cycle
   assign o_pred_taken = bht[idx_f][1];

   assign eq   = i_dat_a == i_dat_b;
   assign lt_s = $signed(i_dat_a) < $signed(i_dat_b);
   assign lt_u = i_dat_a < i_dat_b;

   always_comb begin
      cmp = 1'b0;
      unique case (i_funct3[2:1])
         2'b00:   cmp = eq;
         2'b10:   cmp = lt_s;
         2'b11:   cmp = lt_u;
         default: cmp = 1'b0;
      endcase
   end

   assign cond   = cmp ^ i_funct3[0];
   assign taken  = i_jump | (i_branch & cond);
   assign accept = i_valid & ~i_flush;
   assign upd    = accept & i_branch & ~i_jump;
   assign miss   = taken ^ i_pred;
   assign cur    = bht[idx_e];

   always_comb begin
      nxt = cur;
      if (taken) begin
         if (cur != 2'd3) nxt = cur + 2'd1;
      end else begin
         if (cur != 2'd0) nxt = cur - 2'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'd1;
      end else if (upd) begin
         bht[idx_e] <= nxt;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid      <= 1'b0;
         o_br_en      <= 1'b0;
         o_mispredict <= 1'b0;
      end else begin
         o_valid      <= accept;
         o_br_en      <= accept & taken;
         o_mispredict <= accept & miss;
      end
   end

   // Saturates at all-ones rather than wrapping
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_mispred_cnt <= '0;
      end else if (accept && miss && (o_mispred_cnt != '1)) begin
         o_mispred_cnt <= o_mispred_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_pred.sv
// Self-checking bench for branch_pred against a table/arithmetic model.
// A second instance with a 2-bit miss counter exercises saturation.
module tb_branch_pred;

   localparam int DEPTH = 64;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic [31:0] i_pc_f, i_pc_e, i_dat_a, i_dat_b;
   logic [2:0]  i_funct3;
   logic        i_valid, i_branch, i_jump, i_pred, i_flush;
   logic        o_pred_taken, o_valid, o_br_en, o_mispredict;
   logic [15:0] o_mispred_cnt;
   logic        p2, v2, b2, m2;
   logic [1:0]  cnt2;

   int n_cmp = 0;
   int n_fail = 0;
   int m_bht[DEPTH];
   int m_cnt, m_cnt2;
   bit e_valid, e_br, e_mis;

   always #5 i_clk = ~i_clk;

   branch_pred dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pc_f(i_pc_f),
      .o_pred_taken(o_pred_taken), .i_valid(i_valid), .i_pc_e(i_pc_e),
      .i_dat_a(i_dat_a), .i_dat_b(i_dat_b), .i_funct3(i_funct3),
      .i_branch(i_branch), .i_jump(i_jump), .i_pred(i_pred),
      .i_flush(i_flush), .o_valid(o_valid), .o_br_en(o_br_en),
      .o_mispredict(o_mispredict), .o_mispred_cnt(o_mispred_cnt)
   );

   branch_pred #(.CNT_W(2)) dut2 (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pc_f(i_pc_f),
      .o_pred_taken(p2), .i_valid(i_valid), .i_pc_e(i_pc_e),
      .i_dat_a(i_dat_a), .i_dat_b(i_dat_b), .i_funct3(i_funct3),
      .i_branch(i_branch), .i_jump(i_jump), .i_pred(i_pred),
      .i_flush(i_flush), .o_valid(v2), .o_br_en(b2),
      .o_mispredict(m2), .o_mispred_cnt(cnt2)
   );

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc / 4) % DEPTH);
   endfunction

   function automatic bit pred_of(input logic [31:0] pc);
      return m_bht[idx_of(pc)] >= 2;
   endfunction

   function automatic bit cond_of(input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] f3);
      bit c;
      case (f3[2:1])
         2'b00:   c = (a == b);
         2'b10:   c = ($signed(a) < $signed(b));
         2'b11:   c = (a < b);
         default: c = 1'b0;
      endcase
      return c ^ f3[0];
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
      m_cnt = 0;
      m_cnt2 = 0;
      e_valid = 0;
      e_br = 0;
      e_mis = 0;
   endfunction

   function automatic void model_step();
      bit tk;
      int k;
      e_valid = 0;
      e_br = 0;
      e_mis = 0;
      if (i_valid && !i_flush) begin
         tk = i_jump || (i_branch && cond_of(i_dat_a, i_dat_b, i_funct3));
         e_valid = 1;
         e_br = tk;
         e_mis = (tk != i_pred);
         if (e_mis) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
         end
         if (i_branch && !i_jump) begin
            k = idx_of(i_pc_e);
            if (tk) m_bht[k] = (m_bht[k] < 3) ? m_bht[k] + 1 : 3;
            else m_bht[k] = (m_bht[k] > 0) ? m_bht[k] - 1 : 0;
         end
      end
   endfunction

   task automatic idle();
      i_valid = 0; i_branch = 0; i_jump = 0; i_pred = 0; i_flush = 0;
      i_pc_e = 0; i_dat_a = 0; i_dat_b = 0; i_funct3 = 0;
   endtask

   task automatic req(input logic [31:0] pc, input logic [31:0] a,
                      input logic [31:0] b, input logic [2:0] f3,
                      input bit br, input bit j, input bit pr, input bit fl);
      i_valid = 1; i_pc_e = pc; i_dat_a = a; i_dat_b = b;
      i_funct3 = f3; i_branch = br; i_jump = j; i_pred = pr; i_flush = fl;
   endtask

   task automatic cyc();
      model_step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      i_rst_n = 0;
      m_reset();
      @(posedge i_clk);
      #1;
      i_rst_n = 1;
   endtask

   task automatic test_reset();
      idle();
      i_pc_f = 0;
      i_rst_n = 0;
      m_reset();
      #3;
      n_cmp++;
      if ({o_valid, o_br_en, o_mispredict, o_mispred_cnt} !== 19'd0) begin
         n_fail++;
         $display("FAIL reset_out: got %b %b %b %0d want 0 0 0 0",
                  o_valid, o_br_en, o_mispredict, o_mispred_cnt);
      end
      for (int i = 0; i < 8; i++) begin
         i_pc_f = $urandom;
         #1;
         n_cmp++;
         if (o_pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pred: pc=%h got %b want 0", i_pc_f, o_pred_taken);
         end
      end
      @(posedge i_clk);
      #1;
      i_rst_n = 1;
      cyc();
      n_cmp++;
      if ({o_valid, o_mispred_cnt} !== 17'd0) begin
         n_fail++;
         $display("FAIL reset_idle: valid=%b cnt=%0d want 0 0", o_valid, o_mispred_cnt);
      end
   endtask

   task automatic test_signed();
      do_reset();
      req(32'h100, 32'hFFFF_FFFF, 32'd1, 3'b100, 1, 0, 0, 0);
      cyc();
      n_cmp++;
      if ({o_valid, o_br_en, o_mispredict, o_mispred_cnt} !== {3'b111, 16'd1}) begin
         n_fail++;
         $display("FAIL blt: got v=%b br=%b mis=%b cnt=%0d want 1 1 1 1",
                  o_valid, o_br_en, o_mispredict, o_mispred_cnt);
      end
      req(32'h100, 32'hFFFF_FFFF, 32'd1, 3'b110, 1, 0, 0, 0);
      cyc();
      n_cmp++;
      if ({o_valid, o_br_en, o_mispredict, o_mispred_cnt} !== {3'b100, 16'd1}) begin
         n_fail++;
         $display("FAIL bltu: got v=%b br=%b mis=%b cnt=%0d want 1 0 0 1",
                  o_valid, o_br_en, o_mispredict, o_mispred_cnt);
      end
      idle();
   endtask

   task automatic test_saturation();
      bit want [9];
      want = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
      do_reset();
      i_pc_f = 32'h40;
      #1;
      n_cmp++;
      if (o_pred_taken !== 1'b0) begin
         n_fail++;
         $display("FAIL sat_pre: got %b want 0", o_pred_taken);
      end
      for (int i = 0; i < 9; i++) begin
         if (i < 4) req(32'h40, 5, 5, 3'b000, 1, 0, 1, 0);
         else req(32'h40, 5, 6, 3'b000, 1, 0, 1, 0);
         cyc();
         n_cmp++;
         if ({o_valid, o_br_en, o_pred_taken} !== {1'b1, i < 4, want[i]}) begin
            n_fail++;
            $display("FAIL sat_step%0d: got v=%b br=%b pred=%b want 1 %b %b",
                     i, o_valid, o_br_en, o_pred_taken, i < 4, want[i]);
         end
      end
      idle();
   endtask

   task automatic test_alias();
      do_reset();
      i_pc_f = 32'h40;
      req(32'h140, 7, 7, 3'b000, 1, 0, 0, 0);
      cyc();
      n_cmp++;
      if (o_pred_taken !== 1'b1) begin
         n_fail++;
         $display("FAIL alias_up: got %b want 1", o_pred_taken);
      end
      req(32'h40, 7, 8, 3'b000, 1, 0, 1, 0);
      i_pc_f = 32'h140;
      cyc();
      n_cmp++;
      if (o_pred_taken !== 1'b0) begin
         n_fail++;
         $display("FAIL alias_down: got %b want 0", o_pred_taken);
      end
      idle();
   endtask

   task automatic test_flush_jump();
      do_reset();
      i_pc_f = 32'h80;
      req(32'h80, 3, 3, 3'b000, 1, 0, 0, 1);
      cyc();
      n_cmp++;
      if ({o_valid, o_pred_taken, o_mispred_cnt} !== 18'd0) begin
         n_fail++;
         $display("FAIL flush: got v=%b pred=%b cnt=%0d want 0 0 0",
                  o_valid, o_pred_taken, o_mispred_cnt);
      end
      req(32'h80, 3, 4, 3'b000, 1, 1, 0, 0);
      cyc();
      n_cmp++;
      if ({o_valid, o_br_en, o_mispredict, o_pred_taken} !== 4'b1110) begin
         n_fail++;
         $display("FAIL jump: got v=%b br=%b mis=%b pred=%b want 1 1 1 0",
                  o_valid, o_br_en, o_mispredict, o_pred_taken);
      end
      req(32'h80, 3, 3, 3'b000, 1, 0, 0, 0);
      cyc();
      n_cmp++;
      if (o_pred_taken !== 1'b1) begin
         n_fail++;
         $display("FAIL jump_ctr: got %b want 1", o_pred_taken);
      end
      idle();
   endtask

   task automatic test_cnt_sat();
      logic [1:0] want [5];
      want = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         req(32'h200, 0, 0, 3'b000, 0, 1, 0, 0);
         cyc();
         n_cmp++;
         if (cnt2 !== want[i] || o_mispred_cnt !== 16'(i + 1)) begin
            n_fail++;
            $display("FAIL cnt_sat%0d: got %0d/%0d want %0d/%0d",
                     i, cnt2, o_mispred_cnt, want[i], i + 1);
         end
      end
      idle();
   endtask

   task automatic test_random();
      logic [31:0] a;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         i_pc_f = 32'(($urandom % 8) * 4 + (($urandom % 2) * 256));
         a = ($urandom % 2) ? $urandom : 32'($urandom % 4);
         req(32'(($urandom % 8) * 4 + (($urandom % 2) * 256)), a,
             ($urandom % 3 == 0) ? a : (($urandom % 2) ? $urandom : 32'($urandom % 4)),
             3'($urandom), ($urandom % 4) != 0, ($urandom % 6) == 0,
             1'($urandom), ($urandom % 8) == 0);
         i_valid = ($urandom % 5) != 0;
         #1;
         n_cmp++;
         if ({o_pred_taken, p2} !== {2{pred_of(i_pc_f)}}) begin
            n_fail++;
            $display("FAIL rnd_pred%0d: pc=%h got %b/%b want %b",
                     i, i_pc_f, o_pred_taken, p2, pred_of(i_pc_f));
         end
         cyc();
         n_cmp++;
         if ({o_valid, o_br_en, o_mispredict, o_mispred_cnt, v2, b2, m2, cnt2}
             !== {e_valid, e_br, e_mis, 16'(m_cnt), e_valid, e_br, e_mis, 2'(m_cnt2)}) begin
            n_fail++;
            $display("FAIL rnd_out%0d: got %b%b%b c=%0d c2=%0d want %b%b%b c=%0d c2=%0d",
                     i, o_valid, o_br_en, o_mispredict, o_mispred_cnt, cnt2,
                     e_valid, e_br, e_mis, m_cnt, m_cnt2);
         end
      end
      idle();
   endtask

   task automatic test_midreset();
      do_reset();
      i_pc_f = 32'h40;
      req(32'h40, 1, 1, 3'b000, 1, 0, 0, 0);
      cyc();
      req(32'h40, 1, 1, 3'b000, 1, 0, 0, 0);
      cyc();
      req(32'h40, 9, 9, 3'b000, 1, 0, 0, 0);
      #2;
      i_rst_n = 0;
      m_reset();
      #1;
      n_cmp++;
      if ({o_valid, o_br_en, o_mispredict, o_mispred_cnt, o_pred_taken} !== 20'd0) begin
         n_fail++;
         $display("FAIL midrst_now: got v=%b br=%b mis=%b cnt=%0d pred=%b want 0",
                  o_valid, o_br_en, o_mispredict, o_mispred_cnt, o_pred_taken);
      end
      @(posedge i_clk);
      #1;
      n_cmp++;
      if ({o_valid, o_pred_taken} !== 2'b00) begin
         n_fail++;
         $display("FAIL midrst_hold: v=%b pred=%b want 0 0", o_valid, o_pred_taken);
      end
      idle();
      i_rst_n = 1;
      req(32'h40, 4, 4, 3'b000, 1, 0, 0, 0);
      cyc();
      n_cmp++;
      if ({o_valid, o_br_en, o_pred_taken} !== 3'b111) begin
         n_fail++;
         $display("FAIL midrst_after: v=%b br=%b pred=%b want 1 1 1",
                  o_valid, o_br_en, o_pred_taken);
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_signed();
      test_saturation();
      test_alias();
      test_flush_jump();
      test_cnt_sat();
      test_random();
      test_midreset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
